// File: rtl/vend_pkg.sv
// Shared types and constants for the coin vending controller.
// Coin codes double as change-coin codes (01 nickel, 10 dime).
package vend_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    localparam logic [2:0] NICKEL_U  = 3'd1;
    localparam logic [2:0] DIME_U    = 3'd2;
    localparam logic [2:0] QUARTER_U = 3'd5;

    function automatic logic [2:0] coin_value(input logic [1:0] c);
        case (c)
            COIN_NICKEL:  coin_value = NICKEL_U;
            COIN_DIME:    coin_value = DIME_U;
            COIN_QUARTER: coin_value = QUARTER_U;
            default:      coin_value = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Change-coin selector: largest coin (dime/nickel) not exceeding the credit.
// Latency: combinational. Backpressure: none.
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 4
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [1:0]          change_coin,
    output logic [1:0]          dec
);

    always_comb begin
        change_coin = COIN_NONE;
        dec         = 2'd0;
        if (credit >= CREDIT_W'(2)) begin
            change_coin = COIN_DIME;
            dec         = 2'd2;
        end else if (credit != '0) begin
            change_coin = COIN_NICKEL;
            dec         = 2'd1;
        end
    end

endmodule

// File: rtl/vend_multi.sv
// Parametrised vending controller: accumulate coins, vend at PRICE, pay out change. Optional refund: VEND_CANCEL_EN.
// Latency: newspaper one cycle after the coin edge reaching PRICE; change starts the cycle after.
// Backpressure: coin_ready low outside ACCUM; coins offered then are rejected with a registered coin_bounce pulse.
module vend_multi
    import vend_pkg::*;
#(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 4,
    parameter int COUNT_W  = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                coin_ready,
    output logic                coin_bounce,
    output logic                newspaper,
    output logic [1:0]          change_coin,
    output logic [CREDIT_W-1:0] credit,
    output logic [COUNT_W-1:0]  vend_count
);

    localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [COUNT_W-1:0]  count_nxt;
    logic                bounce_nxt;
    logic                cancel_take;
    logic                coin_vld;
    logic [CREDIT_W:0]   coin_u;
    logic [CREDIT_W:0]   sum;
    logic [1:0]          gen_coin;
    logic [1:0]          gen_dec;

    vend_change_gen #(.CREDIT_W(CREDIT_W)) u_change_gen (
        .credit      (credit),
        .change_coin (gen_coin),
        .dec         (gen_dec)
    );

`ifdef VEND_CANCEL_EN
    assign cancel_take = (state == ACCUM) && cancel && (credit != '0);
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign cancel_take   = 1'b0;
`endif

    assign coin_vld = (coin != COIN_NONE);
    assign coin_u   = (CREDIT_W+1)'(coin_value(coin));
    assign sum      = {1'b0, credit} + coin_u;

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        count_nxt  = vend_count;
        bounce_nxt = 1'b0;
        case (state)
            ACCUM: begin
                if (cancel_take) begin
                    // refund path reuses the change payout; the coin loses to cancel
                    state_nxt  = CHANGE;
                    bounce_nxt = coin_vld;
                end else if (coin_vld) begin
                    credit_nxt = sum[CREDIT_W-1:0];
                    if (sum >= PRICE_X)
                        state_nxt = VEND;
                end
            end
            VEND: begin
                bounce_nxt = coin_vld;
                credit_nxt = credit - PRICE_C;
                if (vend_count != '1)
                    count_nxt = vend_count + COUNT_W'(1);
                state_nxt = (credit != PRICE_C) ? CHANGE : ACCUM;
            end
            CHANGE: begin
                bounce_nxt = coin_vld;
                credit_nxt = credit - CREDIT_W'(gen_dec);
                if (credit == CREDIT_W'(gen_dec))
                    state_nxt = ACCUM;
            end
            default: begin
                state_nxt  = ACCUM;
                credit_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ACCUM;
            credit      <= '0;
            vend_count  <= '0;
            coin_bounce <= 1'b0;
        end else begin
            state       <= state_nxt;
            credit      <= credit_nxt;
            vend_count  <= count_nxt;
            coin_bounce <= bounce_nxt;
        end
    end

    assign coin_ready  = (state == ACCUM);
    assign newspaper   = (state == VEND);
    assign change_coin = (state == CHANGE) ? gen_coin : COIN_NONE;

endmodule

// File: tb/tb_vend_multi.sv
// Randomized and directed bench for vend_multi against a transaction-level model.
// A second instance with COUNT_W=2 checks counter saturation on the same stimulus.
module tb_vend_multi;

    localparam int PRICE    = 3;
    localparam int CREDIT_W = 4;
`ifdef VEND_CANCEL_EN
    localparam bit CANCEL_ON = 1'b1;
`else
    localparam bit CANCEL_ON = 1'b0;
`endif

    logic                clock;
    logic                reset;
    logic [1:0]          coin;
    logic                cancel;
    logic                coin_ready, coin_bounce, newspaper;
    logic [1:0]          change_coin;
    logic [CREDIT_W-1:0] credit;
    logic [7:0]          vend_count;

    logic                coin_ready2, coin_bounce2, newspaper2;
    logic [1:0]          change_coin2;
    logic [CREDIT_W-1:0] credit2;
    logic [1:0]          vend_count2;

    vend_multi #(.PRICE(PRICE), .CREDIT_W(CREDIT_W), .COUNT_W(8)) dut (
        .clock(clock), .reset(reset), .coin(coin), .cancel(cancel),
        .coin_ready(coin_ready), .coin_bounce(coin_bounce), .newspaper(newspaper),
        .change_coin(change_coin), .credit(credit), .vend_count(vend_count)
    );

    vend_multi #(.PRICE(PRICE), .CREDIT_W(CREDIT_W), .COUNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .coin(coin), .cancel(cancel),
        .coin_ready(coin_ready2), .coin_bounce(coin_bounce2), .newspaper(newspaper2),
        .change_coin(change_coin2), .credit(credit2), .vend_count(vend_count2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Model: while idle, credit accumulates; a purchase or refund schedules
    // a list of per-cycle output expectations that plays out before idling again.
    typedef struct {
        bit       np;
        bit [1:0] chg;
        int       cr;
    } slot_t;

    slot_t sched[$];
    int    m_credit;
    int    m_count;
    bit    m_bounce;
    int    n_checks;
    int    n_pass;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int coin_units(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    task automatic push_change(input int r);
        slot_t s;
        while (r > 0) begin
            s.np  = 1'b0;
            s.cr  = r;
            s.chg = (r >= 2) ? 2'b10 : 2'b01;
            sched.push_back(s);
            r -= (r >= 2) ? 2 : 1;
        end
    endtask

    task automatic check_outputs();
        bit busy;
        busy = (sched.size() > 0);
        check("coin_ready", int'(coin_ready), busy ? 0 : 1);
        check("coin_bounce", int'(coin_bounce), int'(m_bounce));
        check("newspaper", int'(newspaper), busy ? int'(sched[0].np) : 0);
        check("change_coin", int'(change_coin), busy ? int'(sched[0].chg) : 0);
        check("credit", int'(credit), busy ? sched[0].cr : m_credit);
        check("vend_count", int'(vend_count), m_count);
        check("vend_count_sat", int'(vend_count2), (m_count > 3) ? 3 : m_count);
    endtask

    task automatic model_step(input logic [1:0] c, input logic cn);
        bit    busy, take;
        int    s;
        slot_t v;
        busy     = (sched.size() > 0);
        take     = CANCEL_ON && !busy && cn && (m_credit > 0);
        m_bounce = (c != 2'b00) && (busy || take);
        if (busy) begin
            if (sched[0].np) m_count++;
            void'(sched.pop_front());
        end else if (take) begin
            push_change(m_credit);
            m_credit = 0;
        end else if (c != 2'b00) begin
            s = m_credit + coin_units(c);
            if (s >= PRICE) begin
                v.np = 1'b1; v.chg = 2'b00; v.cr = s;
                sched.push_back(v);
                push_change(s - PRICE);
                m_credit = 0;
            end else begin
                m_credit = s;
            end
        end
    endtask

    task automatic cycle(input logic [1:0] c, input logic cn);
        @(negedge clock);
        check_outputs();
        coin   = c;
        cancel = cn;
        model_step(c, cn);
        @(posedge clock);
    endtask

    task automatic model_reset();
        sched.delete();
        m_credit = 0;
        m_count  = 0;
        m_bounce = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        model_reset();
        coin   = 2'b00;
        cancel = 1'b0;
        reset  = 1'b1;
        #1;
        check_outputs();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // three nickels, exact price
        cycle(2'b01, 0); cycle(2'b01, 0); cycle(2'b01, 0); cycle(2'b00, 0); cycle(2'b00, 0);
        // single quarter: vend then one dime
        cycle(2'b11, 0); cycle(2'b00, 0); cycle(2'b00, 0); cycle(2'b00, 0);
        // nickel + quarter: dime then nickel change
        cycle(2'b01, 0); cycle(2'b11, 0);
        for (int i = 0; i < 4; i++) cycle(2'b00, 0);
        // coins offered while busy bounce
        cycle(2'b11, 0); cycle(2'b10, 0); cycle(2'b10, 0); cycle(2'b00, 0); cycle(2'b00, 0);

        // async reset while paying a dime of change
        cycle(2'b11, 0); cycle(2'b00, 0);
        @(negedge clock);
        check_outputs();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clock);
        #2;
        reset = 1'b0;
        cycle(2'b00, 0); cycle(2'b00, 0);

        // dime then cancel together with a nickel
        cycle(2'b10, 0); cycle(2'b01, 1);
        for (int i = 0; i < 4; i++) cycle(2'b00, 0);

        // five vends to saturate the narrow counter
        for (int i = 0; i < 5; i++) begin
            cycle(2'b11, 0); cycle(2'b00, 0); cycle(2'b00, 0); cycle(2'b00, 0);
        end

        for (int i = 0; i < 600; i++) begin
            logic [1:0] c;
            logic       cn;
            c  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            cn = ($urandom_range(0, 7) == 0);
            cycle(c, cn);
        end
        cycle(2'b00, 0);
        @(negedge clock);
        check_outputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
